mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the single external audio-memory port among the audio engines (play, record, pitch, mix, load).
//  Round-robin arbitration, one word per grant, optional lock for back-to-back bursts.
//  Sits between the engines sequenced by the control core and the memory controller.
// PARAMETERS
//  NUM_REQ  5   number of requesters (index = priority slot, see package constants)
//  ADDR_W   23  word address width
//  DATA_W   16  data word width
// PORTS
//  i_clk      in   1                 system clock; sole clock domain
//  i_rst      in   1                 asynchronous, active-low reset
//  i_req      in   NUM_REQ           per-requester request; held until its o_done pulse
//  i_lock     in   NUM_REQ           keep the port for the next access of the same requester
//  i_we       in   NUM_REQ           1 = write, 0 = read
//  i_addr     in   ADDR_W  x NUM_REQ per-requester address (unpacked array)
//  i_wdata    in   DATA_W  x NUM_REQ per-requester write data (unpacked array)
//  o_grant    out  NUM_REQ           one-hot owner of the current access; 0 when idle
//  o_done     out  NUM_REQ           one-hot, 1-cycle pulse: access finished
//  o_rdata    out  DATA_W            read data; valid while o_done is high for a read
//  mem_req    out  1                 request to the memory controller, held until mem_ack
//  mem_we     out  1                 latched write enable
//  mem_addr   out  ADDR_W            latched address
//  mem_wdata  out  DATA_W            latched write data
//  mem_ack    in   1                 1-cycle completion from the controller
//  mem_rdata  in   DATA_W            read data, valid with mem_ack
// BEHAVIOUR
//  Reset (i_rst=0, async): state=IDLE, rr_ptr=0, lock_owner invalid, all outputs 0.
//  FSM with states IDLE, ISSUE, DONE:
//   IDLE: if any i_req, pick the winner, latch we/addr/wdata into mem_*, set o_grant, mem_req=1 -> ISSUE.
//   ISSUE: hold mem_req and the latched fields; on mem_ack capture mem_rdata into o_rdata -> DONE.
//   DONE: o_done[winner]=1 for exactly this cycle; mem_req=0; no arbitration -> IDLE.
//     The winner uses this cycle to drop or renew i_req.
//  Winner selection: if lock_owner is valid and i_req[lock_owner]=1, lock_owner wins.
//   Otherwise the winner is the first requester at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
//  On every grant: rr_ptr <= winner+1 (mod NUM_REQ).
//   lock_owner <= winner if i_lock[winner] is sampled high in DONE, else invalid.
//  Latency: i_req rises at cycle 0 -> mem_req at cycle 1; mem_ack at cycle k -> o_done at cycle k+1.
//   Minimum 3 cycles per access.
//  A locked owner that is no longer requesting in IDLE releases the lock; plain round-robin applies.
//  i_req dropped during ISSUE: the access still completes and o_done still pulses (no abort).
//  Input changes after the IDLE latch are ignored until the next grant.
//  mem_ack outside ISSUE is ignored.
//  o_grant is constant through ISSUE and DONE.
//  o_rdata holds its last value until the next read ack.
//  Reset mid-access drops mem_req immediately; the controller must tolerate an abandoned request.
// CONFIGURATION
//  PLAY_PRIORITY_EN defined:
//   In IDLE, i_req[REQ_PLAY] beats both the lock owner and round-robin, to protect real-time playback.
//   rr_ptr and lock rules are unchanged for all other grants.
//  PLAY_PRIORITY_EN undefined: pure lock + round-robin, no fixed priority.
// STRUCTURE
//  Package audio_mem_pkg:
//   ADDR_W/DATA_W defaults
//   requester indices REQ_PLAY=0, REQ_RECORD=1, REQ_PITCH=2, REQ_MIX=3, REQ_LOAD=4
//   arb_state_t enum {IDLE, ISSUE, DONE}
//  Sub-module rr_pick: combinational req + rr_ptr -> one-hot winner plus index.
//   The FSM, latches, lock and priority override stay in mem_access_arbiter.
// TESTING
//  1 Single read: i_req=5'b00100, addr=23'h00_1234, mem_ack 2 cycles after mem_req with rdata=16'hBEEF
//    -> mem_addr=23'h001234, o_done=5'b00100 one cycle after ack, o_rdata=16'hBEEF.
//  2 All five requesting continuously, rr_ptr=0, ack every access
//    -> grant order 0,1,2,3,4,0; each o_done exactly once per round.
//  3 Requester 3 with i_lock=1 for 4 accesses while 1 also requests
//    -> four consecutive grants to 3, then 1; rr_ptr=4 after the lock ends.
//  4 Requester 2 write (data 16'h00FF), i_req dropped during ISSUE
//    -> mem_we=1, mem_wdata=16'h00FF held until ack, o_done[2] still pulses.
//  5 i_rst asserted low during ISSUE -> mem_req, o_grant, o_done are 0 at once; after release the first grant goes to index 0.
//  6 With PLAY_PRIORITY_EN: 3 locked and 0 requests -> 0 granted next.
//    Without PLAY_PRIORITY_EN: 3 keeps the port.

Source files
------------

// File: rtl/audio_mem_pkg.sv
// Shared constants and types for the audio-memory port arbiter.
// Requester indices double as round-robin slots; REQ_PLAY is the real-time playback engine.
package audio_mem_pkg;
  localparam int NUM_REQ_DEF = 5;
  localparam int ADDR_W_DEF  = 23;
  localparam int DATA_W_DEF  = 16;

  localparam int REQ_PLAY   = 0;
  localparam int REQ_RECORD = 1;
  localparam int REQ_PITCH  = 2;
  localparam int REQ_MIX    = 3;
  localparam int REQ_LOAD   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_access_arbiter_if.sv
// Memory-controller side of the arbiter: one request held until a 1-cycle ack.
// master = arbiter (drives request and latched fields), slave = memory controller.
interface mem_access_arbiter_if
  import audio_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping N-1 -> 0.
// Zero latency; vld_o low (and gnt_o zero) when nobody requests.
module rr_pick
  import audio_mem_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  int j;

  // Scan from the farthest offset down so the nearest requester overwrites the rest.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        vld_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin + lock arbiter for the audio-memory port; PLAY_PRIORITY_EN lets REQ_PLAY override lock and rotation.
// Min 3 cycles/access (grant, wait ack, done pulse); mem_req held until mem_ack, requesters hold i_req until o_done.
module mem_access_arbiter
  import audio_mem_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [NUM_REQ-1:0]  i_lock,
  input  logic [NUM_REQ-1:0]  i_we,
  input  logic [ADDR_W-1:0]   i_addr  [NUM_REQ],
  input  logic [DATA_W-1:0]   i_wdata [NUM_REQ],
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [NUM_REQ-1:0]  o_done,
  output logic [DATA_W-1:0]   o_rdata,
  mem_access_arbiter_if.master mem
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic               lock_vld_q, lock_vld_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [NUM_REQ-1:0] rr_gnt, pick_gnt;
  logic [IDX_W-1:0]   rr_idx, pick_idx;
  logic               rr_vld;

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_rr_pick (
    .req_i (i_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .vld_o (rr_vld)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_idx_d   = win_idx_q;
    lock_idx_d  = lock_idx_q;
    lock_vld_d  = lock_vld_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;

    pick_gnt = rr_gnt;
    pick_idx = rr_idx;
    if (lock_vld_q && i_req[lock_idx_q]) begin
      pick_gnt             = '0;
      pick_gnt[lock_idx_q] = 1'b1;
      pick_idx             = lock_idx_q;
    end
`ifdef PLAY_PRIORITY_EN
    if (i_req[REQ_PLAY]) begin
      pick_gnt           = '0;
      pick_gnt[REQ_PLAY] = 1'b1;
      pick_idx           = IDX_W'(REQ_PLAY);
    end
`endif

    case (state_q)
      IDLE: begin
        if (lock_vld_q && !i_req[lock_idx_q]) lock_vld_d = 1'b0;
        if (rr_vld) begin
          state_d     = ISSUE;
          grant_d     = pick_gnt;
          win_idx_d   = pick_idx;
          rr_ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = i_we[pick_idx];
          mem_addr_d  = i_addr[pick_idx];
          mem_wdata_d = i_wdata[pick_idx];
        end
      end
      ISSUE: begin
        if (mem.mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) rdata_d = mem.mem_rdata;
        end
      end
      DONE: begin
        // Lock decision is taken while the owner sees its o_done pulse.
        state_d    = IDLE;
        grant_d    = '0;
        lock_vld_d = i_lock[win_idx_q];
        lock_idx_d = win_idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_idx_q   <= '0;
      lock_idx_q  <= '0;
      lock_vld_q  <= 1'b0;
      grant_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_idx_q   <= win_idx_d;
      lock_idx_q  <= lock_idx_d;
      lock_vld_q  <= lock_vld_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_done        = (state_q == DONE) ? grant_q : '0;
  assign o_rdata       = rdata_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter: acts as the memory controller and checks every
// grant, held field, done pulse and read value against a queue-free arbitration model.
module tb_mem_access_arbiter;
  import audio_mem_pkg::*;

  localparam int N  = NUM_REQ_DEF;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [N-1:0]  i_req, i_lock, i_we;
  logic [AW-1:0] i_addr  [N];
  logic [DW-1:0] i_wdata [N];
  logic [N-1:0]  o_grant, o_done;
  logic [DW-1:0] o_rdata;

  mem_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_access_arbiter dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_lock  (i_lock),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_grant (o_grant),
    .o_done  (o_done),
    .o_rdata (o_rdata),
    .mem     (mif)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: rotation pointer, lock owner, last read value.
  int            m_ptr;
  bit            m_lock_vld;
  int            m_lock_idx;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] addr_tb  [N];
  logic [DW-1:0] wdata_tb [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] req);
`ifdef PLAY_PRIORITY_EN
    if (req[REQ_PLAY]) return REQ_PLAY;
`endif
    if (m_lock_vld && req[m_lock_idx]) return m_lock_idx;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction

  task automatic do_access(input logic [N-1:0] req, input logic [N-1:0] we,
                           input logic [N-1:0] lock, input int dly, input bit drop,
                           input logic [DW-1:0] rd, output logic [N-1:0] g, output int lat);
    int w;
    logic [N-1:0] exp_g;
    i_req = req;
    i_we  = we;
    for (int j = 0; j < N; j++) begin
      i_addr[j]  = addr_tb[j];
      i_wdata[j] = wdata_tb[j];
    end
    if (m_lock_vld && !req[m_lock_idx]) m_lock_vld = 1'b0;
    w     = model_pick(req);
    m_ptr = (w + 1) % N;
    exp_g = '0;
    exp_g[w] = 1'b1;

    lat = 0;
    do begin
      @(posedge i_clk); #1;
      mif.mem_ack = 1'b0;
      lat++;
      if (!mif.mem_req) begin
        check_eq("idle_grant", 64'(o_grant), 64'(0));
        check_eq("idle_done", 64'(o_done), 64'(0));
      end
    end while (!mif.mem_req && lat < 8);
    g = o_grant;
    check_eq("mem_req_rise", 64'(mif.mem_req), 64'(1));
    check_eq("grant", 64'(o_grant), 64'(exp_g));
    check_eq("latched", 64'({mif.mem_we, mif.mem_addr, mif.mem_wdata}),
             64'({we[w], addr_tb[w], wdata_tb[w]}));

    // Disturb the winner's inputs; the latched fields must not follow.
    i_addr[w]  = ~addr_tb[w];
    i_wdata[w] = ~wdata_tb[w];
    i_we[w]    = ~we[w];
    if (drop) i_req[w] = 1'b0;

    repeat (dly) begin
      @(posedge i_clk); #1;
      check_eq("hold", 64'({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, o_grant, o_done}),
               64'({1'b1, we[w], addr_tb[w], wdata_tb[w], exp_g, {N{1'b0}}}));
    end

    mif.mem_ack   = 1'b1;
    mif.mem_rdata = rd;
    @(posedge i_clk); #1;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = DW'($urandom);
    if (!we[w]) m_rdata = rd;
    check_eq("done", 64'(o_done), 64'(exp_g));
    check_eq("done_req", 64'(mif.mem_req), 64'(0));
    check_eq("done_grant", 64'(o_grant), 64'(exp_g));
    check_eq("rdata", 64'(o_rdata), 64'(m_rdata));

    i_lock     = lock;
    m_lock_vld = lock[w];
    m_lock_idx = w;
    // Stray ack during DONE must be ignored.
    if ($urandom_range(0, 1) == 1) begin
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = ~m_rdata;
    end
  endtask

  task automatic idle_cycles(input int n);
    i_req = '0;
    m_lock_vld = 1'b0;
    repeat (n) begin
      @(posedge i_clk); #1;
      mif.mem_ack = 1'b0;
      check_eq("idle_req", 64'({mif.mem_req, o_grant, o_done}), 64'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    int lat;
    logic [N-1:0] exp6;
    i_req = '0; i_lock = '0; i_we = '0;
    for (int j = 0; j < N; j++) begin
      i_addr[j] = '0; i_wdata[j] = '0;
      addr_tb[j] = AW'($urandom); wdata_tb[j] = DW'($urandom);
    end
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    m_ptr = 0; m_lock_vld = 1'b0; m_lock_idx = 0; m_rdata = '0;

    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_outputs", 64'({mif.mem_req, mif.mem_we, o_grant, o_done, o_rdata}), 64'(0));
    check_eq("rst_fields", 64'({mif.mem_addr, mif.mem_wdata}), 64'(0));
    #3 i_rst = 1'b1;

    // Single read from requester 2.
    addr_tb[2] = 23'h00_1234;
    do_access(5'b00100, 5'b00000, 5'b00000, 2, 1'b0, 16'hBEEF, g, lat);
    check_eq("t1_latency", 64'(lat), 64'(1));
    check_eq("t1_rdata", 64'(o_rdata), 64'(16'hBEEF));

    // Write from requester 2, request dropped while in flight.
    wdata_tb[2] = 16'h00FF;
    do_access(5'b00100, 5'b00100, 5'b00000, 3, 1'b1, 16'h1111, g, lat);
    check_eq("t4_grant", 64'(g), 64'(5'b00100));

    // Requester 3 locks for four accesses while requester 1 waits.
    do_access(5'b01000, 5'b00000, 5'b01000, 1, 1'b0, 16'h3001, g, lat);
    check_eq("t3_lock0", 64'(g), 64'(5'b01000));
    for (int k = 1; k < 4; k++) begin
      do_access(5'b01010, 5'b00000, (k < 3) ? 5'b01000 : 5'b00000, 0, 1'b0, DW'(16'h3000 + k), g, lat);
      check_eq("t3_lock", 64'(g), 64'(5'b01000));
    end
    do_access(5'b01010, 5'b00000, 5'b00000, 1, 1'b0, 16'h3005, g, lat);
    check_eq("t3_after_lock", 64'(g), 64'(5'b00010));

    // Locked requester 3 against the play engine.
    do_access(5'b01000, 5'b00000, 5'b01000, 0, 1'b0, 16'h6000, g, lat);
    do_access(5'b01001, 5'b00000, 5'b00000, 0, 1'b0, 16'h6001, g, lat);
`ifdef PLAY_PRIORITY_EN
    exp6 = 5'b00001;
`else
    exp6 = 5'b01000;
`endif
    check_eq("t6_play_vs_lock", 64'(g), 64'(exp6));

    // Reset in the middle of an access.
    idle_cycles(1);
    i_req = 5'b00110;
    lat = 0;
    do begin
      @(posedge i_clk); #1;
      mif.mem_ack = 1'b0;
      lat++;
    end while (!mif.mem_req && lat < 8);
    check_eq("t5_issue", 64'(mif.mem_req), 64'(1));
    i_rst = 1'b0;
    #1;
    check_eq("t5_async_rst", 64'({mif.mem_req, o_grant, o_done}), 64'(0));
    #2 i_rst = 1'b1;
    m_ptr = 0; m_lock_vld = 1'b0; m_rdata = '0;

    // Everyone requesting: strict rotation from slot 0.
    for (int k = 0; k < 6; k++) begin
      do_access(5'b11111, 5'b00000, 5'b00000, k % 3, 1'b0, DW'($urandom), g, lat);
      check_eq("t2_rr_order", 64'(g), 64'(5'b00001 << (k % N)));
    end

    // Random traffic.
    for (int it = 0; it < 150; it++) begin
      for (int j = 0; j < N; j++) begin
        addr_tb[j]  = AW'($urandom);
        wdata_tb[j] = DW'($urandom);
      end
      if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3));
      do_access(N'($urandom_range(1, 31)), N'($urandom), N'($urandom & $urandom),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), DW'($urandom), g, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
